// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - two-road intersection phase sequencer driven by a tick strobe
module traffic_phase_controller #(
    parameter int CNT_W      = 8,
    parameter int T_HW_GREEN = 30,
    parameter int T_YELLOW   = 5,
    parameter int T_ALL_RED  = 2,
    parameter int T_FR_GREEN = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       car_detected,
    output logic [1:0] hw_light,
    output logic [1:0] fr_light,
    output logic [2:0] phase,
    output logic       phase_start,
    output logic       car_pending
);
    localparam logic [2:0] S_HW_GREEN  = 3'd0;
    localparam logic [2:0] S_HW_YELLOW = 3'd1;
    localparam logic [2:0] S_RED_A     = 3'd2;
    localparam logic [2:0] S_FR_GREEN  = 3'd3;
    localparam logic [2:0] S_FR_YELLOW = 3'd4;
    localparam logic [2:0] S_RED_B     = 3'd5;

    localparam logic [1:0] L_RED    = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_GREEN  = 2'b10;

    localparam logic [CNT_W-1:0] LD_HW_GREEN = CNT_W'(T_HW_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED  = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_FR_GREEN = CNT_W'(T_FR_GREEN - 1);

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       hw_next, fr_next;
    logic             expired, entering;

    function automatic logic [CNT_W-1:0] load_val(input logic [2:0] s);
        case (s)
            S_HW_YELLOW, S_FR_YELLOW: load_val = LD_YELLOW;
            S_RED_A, S_RED_B:         load_val = LD_ALL_RED;
            S_FR_GREEN:               load_val = LD_FR_GREEN;
            default:                  load_val = LD_HW_GREEN;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HW_GREEN;
            cnt         <= LD_HW_GREEN;
            hw_light    <= L_GREEN;
            fr_light    <= L_RED;
            phase_start <= 1'b0;
            car_pending <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            hw_light    <= hw_next;
            fr_light    <= fr_next;
            phase_start <= entering;
            // Entering FR_GREEN consumes the request even if the sensor fires that same cycle
            if (entering && state_next == S_FR_GREEN)
                car_pending <= 1'b0;
            else if (car_detected && state != S_FR_GREEN)
                car_pending <= 1'b1;
        end
    end

    always_comb begin
        expired    = tick && (cnt == '0);
        state_next = state;
        case (state)
            S_HW_GREEN:  if (expired && (car_pending || car_detected)) state_next = S_HW_YELLOW;
            S_HW_YELLOW: if (expired) state_next = S_RED_A;
            S_RED_A:     if (expired) state_next = S_FR_GREEN;
            S_FR_GREEN:  if (expired) state_next = S_FR_YELLOW;
            S_FR_YELLOW: if (expired) state_next = S_RED_B;
            S_RED_B:     if (expired) state_next = S_HW_GREEN;
            default:     state_next = S_HW_GREEN;
        endcase
        entering = (state_next != state);
        if (entering)
            cnt_next = load_val(state_next);
        else if (tick && cnt != '0)
            cnt_next = cnt - CNT_W'(1);
        else
            cnt_next = cnt;
    end

    always_comb begin
        hw_next = L_RED;
        fr_next = L_RED;
        case (state_next)
            S_HW_GREEN:  hw_next = L_GREEN;
            S_HW_YELLOW: hw_next = L_YELLOW;
            S_FR_GREEN:  fr_next = L_GREEN;
            S_FR_YELLOW: fr_next = L_YELLOW;
            default: ;
        endcase
    end

    assign phase = state;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - self-checking bench for traffic_phase_controller
module tb_traffic_phase_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       car_detected = 1'b0;
    logic [1:0] hw_light, fr_light;
    logic [2:0] phase;
    logic       phase_start, car_pending;

    traffic_phase_controller dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .car_detected(car_detected),
        .hw_light(hw_light), .fr_light(fr_light), .phase(phase),
        .phase_start(phase_start), .car_pending(car_pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference: phase index walks a ring of durations; elapsed ticks counted upward
    int dur [6] = '{30, 5, 2, 15, 5, 2};
    int m_phase = 0;
    int m_elapsed = 0;
    bit m_pending = 0;
    bit m_start = 0;
    int ticks_in [8];
    int starts = 0;

    typedef struct {
        bit t;
        bit c;
        int ph;
        bit st;
        bit pend;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hw_of(input int p);
        return (p == 0) ? 2 : (p == 1) ? 1 : 0;
    endfunction

    function automatic int fr_of(input int p);
        return (p == 3) ? 2 : (p == 4) ? 1 : 0;
    endfunction

    task automatic step(input bit t, input bit c);
        bit chg;
        int np;
        @(negedge clk);
        tick = t;
        car_detected = c;
        if (t) ticks_in[phase]++;
        chg = 0;
        np = m_phase;
        if (t && m_elapsed >= dur[m_phase] - 1 && (m_phase != 0 || m_pending || c)) begin
            np = (m_phase + 1) % 6;
            chg = 1;
        end
        if (chg) m_elapsed = 0;
        else if (t && m_elapsed < 1000) m_elapsed++;
        if (chg && np == 3) m_pending = 0;
        else if (c && m_phase != 3) m_pending = 1;
        m_phase = np;
        m_start = chg;
        @(posedge clk);
        #1;
        if (phase_start) starts++;
        check("phase", int'(phase), m_phase);
        check("hw_light", int'(hw_light), hw_of(m_phase));
        check("fr_light", int'(fr_light), fr_of(m_phase));
        check("phase_start", int'(phase_start), int'(m_start));
        check("car_pending", int'(car_pending), int'(m_pending));
    endtask

    task automatic tick4(input bit c);
        step(0, c);
        step(0, 0);
        step(0, 0);
        step(1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick = 1'b0;
        car_detected = 1'b0;
        #1;
        check("rst_hw", int'(hw_light), 2);
        check("rst_fr", int'(fr_light), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_start", int'(phase_start), 0);
        check("rst_pending", int'(car_pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = 0;
        m_elapsed = 0;
        m_pending = 0;
        m_start = 0;
    endtask

    task automatic wait_phase(input int target, input string name);
        int n = 0;
        while (int'(phase) != target && n < 300) begin
            tick4(0);
            n++;
        end
        check(name, int'(phase), target);
    endtask

    // Every clk: heads never both non-RED, and an idle tick never leaves HW_GREEN
    always @(posedge clk) begin
        logic [2:0] ph;
        logic pd, cd, r;
        ph = phase;
        pd = car_pending;
        cd = car_detected;
        r = rst_n;
        #1;
        if (rst_n) begin
            if (hw_light != 2'b00 && fr_light != 2'b00)
                check("both_non_red", 1, 0);
            if (r && ph == 3'd0 && !pd && !cd)
                check("idle_hold", int'(phase), 0);
        end
    end

    initial begin
        vecs[0] = '{t: 0, c: 0, ph: 0, st: 0, pend: 0};
        vecs[1] = '{t: 1, c: 0, ph: 0, st: 0, pend: 0};
        vecs[2] = '{t: 0, c: 1, ph: 0, st: 0, pend: 1};
        vecs[3] = '{t: 0, c: 0, ph: 0, st: 0, pend: 1};
        vecs[4] = '{t: 1, c: 0, ph: 0, st: 0, pend: 1};
        vecs[5] = '{t: 1, c: 1, ph: 0, st: 0, pend: 1};
        vecs[6] = '{t: 0, c: 0, ph: 0, st: 0, pend: 1};
        vecs[7] = '{t: 1, c: 0, ph: 0, st: 0, pend: 1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].t, vecs[i].c);
            check("vec_phase", int'(phase), vecs[i].ph);
            check("vec_start", int'(phase_start), int'(vecs[i].st));
            check("vec_pending", int'(car_pending), int'(vecs[i].pend));
        end

        // No traffic for 200 ticks: HW stays green
        do_reset();
        starts = 0;
        for (int i = 0; i < 200; i++) tick4(0);
        check("idle_phase", int'(phase), 0);
        check("idle_starts", starts, 0);

        // One car at tick 3 gives one complete service cycle
        do_reset();
        for (int i = 0; i < 8; i++) ticks_in[i] = 0;
        starts = 0;
        tick4(0);
        tick4(0);
        tick4(1);
        begin
            int n = 0;
            bit seen5 = 0;
            while (!(seen5 && phase == 3'd0) && n < 300) begin
                tick4(0);
                if (phase == 3'd5) seen5 = 1;
                n++;
            end
            check("cycle_done", int'(seen5 && phase == 3'd0), 1);
        end
        check("dur_hw_green", ticks_in[0], 30);
        check("dur_hw_yellow", ticks_in[1], 5);
        check("dur_red_a", ticks_in[2], 2);
        check("dur_fr_green", ticks_in[3], 15);
        check("dur_fr_yellow", ticks_in[4], 5);
        check("dur_red_b", ticks_in[5], 2);
        check("cycle_starts", starts, 6);
        check("cycle_pending", int'(car_pending), 0);

        // Pulse during HW_YELLOW latches; pulse during FR_YELLOW brings a second service
        step(0, 1);
        wait_phase(1, "reach_hw_yellow");
        step(0, 1);
        check("yellow_latch", int'(car_pending), 1);
        wait_phase(4, "reach_fr_yellow");
        check("fr_entry_clear", int'(car_pending), 0);
        step(0, 1);
        check("fr_yellow_latch", int'(car_pending), 1);
        wait_phase(0, "back_hw_green");
        for (int i = 0; i < 8; i++) ticks_in[i] = 0;
        wait_phase(3, "second_service");
        check("second_hw_green", ticks_in[0], 30);

        // Tick starvation mid FR_GREEN freezes everything
        tick4(0);
        tick4(0);
        tick4(0);
        for (int i = 0; i < 100; i++) step(0, i[0]);
        check("frozen_phase", int'(phase), 3);
        for (int i = 0; i < 8; i++) ticks_in[i] = 0;
        wait_phase(4, "resume_fr_yellow");
        check("resume_fr_green", ticks_in[3], 12);
        wait_phase(0, "resume_hw_green");

        // Reset in FR_GREEN with cnt=7
        step(0, 1);
        wait_phase(3, "reach_fr_green");
        for (int i = 0; i < 7; i++) tick4(0);
        check("pre_reset_phase", int'(phase), 3);
        do_reset();

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
